// File: rtl/can_msg_fifo_if.sv
// Handshake and status bundle between the CAN register block and the message FIFO.
// The FIFO takes the slave view; the producer/consumer logic takes the master view.
interface can_msg_fifo_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 3
);
    logic                  i_flush;
    logic                  i_wr_en;
    logic [DATA_WIDTH-1:0] i_fifo_w_data;
    logic                  i_r_en;
    logic                  i_clr_err;
    logic [DATA_WIDTH-1:0] o_fifo_r_data;
    logic                  o_r_valid;
    logic [ADDR_WIDTH:0]   o_count;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_almost_full;
    logic                  o_almost_empty;
    logic                  o_overflow;
    logic                  o_underflow;

    modport slave (
        input  i_flush, i_wr_en, i_fifo_w_data, i_r_en, i_clr_err,
        output o_fifo_r_data, o_r_valid, o_count, o_full, o_empty,
               o_almost_full, o_almost_empty, o_overflow, o_underflow
    );

    modport master (
        output i_flush, i_wr_en, i_fifo_w_data, i_r_en, i_clr_err,
        input  o_fifo_r_data, o_r_valid, o_count, o_full, o_empty,
               o_almost_full, o_almost_empty, o_overflow, o_underflow
    );
endinterface

// File: rtl/can_msg_fifo.sv
// Parametrised CAN frame FIFO: count-based full/empty, programmable almost flags,
// sticky overflow/underflow, synchronous flush, registered or FWFT read port.
module can_msg_fifo #(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDR_WIDTH    = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1,
    parameter bit FWFT          = 1'b0
) (
    input  logic           i_sys_clk,
    input  logic           i_reset,
    can_msg_fifo_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0]         CNT_ONE = 1;
    localparam logic [CW-1:0]         AF_T    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0]         AE_T    = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
    logic [CW-1:0]         count_q, count_nxt;
    logic                  full_q, empty_q, afull_q, aempty_q;
    logic                  ovf_q, udf_q;
    logic                  wr_ok, rd_ok;

    // Accept decisions use only registered state, so a pop at full frees room for a push.
    always_comb begin
        rd_ok     = bus.i_r_en & ~empty_q;
        wr_ok     = bus.i_wr_en & (~full_q | rd_ok);
        count_nxt = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count_q + CNT_ONE;
            2'b01:   count_nxt = count_q - CNT_ONE;
            default: count_nxt = count_q;
        endcase
    end

    // NOTE: the frame store has no reset; contents are only observable through valid pointers.
    always_ff @(posedge i_sys_clk) begin
        if (wr_ok && !i_reset && !bus.i_flush)
            mem[w_ptr] <= bus.i_fifo_w_data;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else if (bus.i_flush) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            if (wr_ok) w_ptr <= w_ptr + PTR_ONE;
            if (rd_ok) r_ptr <= r_ptr + PTR_ONE;
            count_q  <= count_nxt;
            full_q   <= (count_nxt == CW'(DEPTH));
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= AF_T);
            aempty_q <= (count_nxt <= AE_T);
            // A new error in the clearing cycle wins over the clear.
            ovf_q    <= (ovf_q & ~bus.i_clr_err) | (bus.i_wr_en & ~wr_ok);
            udf_q    <= (udf_q & ~bus.i_clr_err) | (bus.i_r_en & ~rd_ok);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head is shown directly; forced to zero while empty so reset/flush read as zero.
            assign bus.o_fifo_r_data = empty_q ? '0 : mem[r_ptr];
            assign bus.o_r_valid     = ~empty_q;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  rvalid_q;

            always_ff @(posedge i_sys_clk) begin
                if (i_reset) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else if (bus.i_flush) begin
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_ok;
                    if (rd_ok) rdata_q <= mem[r_ptr];
                end
            end

            assign bus.o_fifo_r_data = rdata_q;
            assign bus.o_r_valid     = rvalid_q;
        end
    endgenerate

    assign bus.o_count        = count_q;
    assign bus.o_full         = full_q;
    assign bus.o_empty        = empty_q;
    assign bus.o_almost_full  = afull_q;
    assign bus.o_almost_empty = aempty_q;
    assign bus.o_overflow     = ovf_q;
    assign bus.o_underflow    = udf_q;
endmodule

// File: tb/tb_can_msg_fifo.sv
// Directed bench for can_msg_fifo: a 4-entry registered-read instance and a 4-entry FWFT instance.
module tb_can_msg_fifo;
    localparam int DW = 128;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    can_msg_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_r ();
    can_msg_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_f ();

    can_msg_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(3),
                   .AEMPTY_THRESH(1), .FWFT(1'b0))
        u_reg (.i_sys_clk(clk), .i_reset(rst), .bus(if_r.slave));

    can_msg_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(3),
                   .AEMPTY_THRESH(1), .FWFT(1'b1))
        u_fwft (.i_sys_clk(clk), .i_reset(rst), .bus(if_f.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one registered-read instance cycle: wr, rd, data, flush, clr.
    task automatic drive_r(input logic wr, input logic rd, input logic [DW-1:0] d,
                           input logic fl, input logic clr);
        if_r.i_wr_en = wr; if_r.i_r_en = rd; if_r.i_fifo_w_data = d;
        if_r.i_flush = fl; if_r.i_clr_err = clr;
    endtask

    task automatic drive_f(input logic wr, input logic rd, input logic [DW-1:0] d);
        if_f.i_wr_en = wr; if_f.i_r_en = rd; if_f.i_fifo_w_data = d;
        if_f.i_flush = 1'b0; if_f.i_clr_err = 1'b0;
    endtask

    initial begin
        drive_r(0, 0, '0, 0, 0);
        drive_f(0, 0, '0);

        // Reset then idle
        rst = 1'b1; tick(); tick();
        rst = 1'b0; tick();
        chk("rst_count",  if_r.o_count, 0);
        chk("rst_empty",  if_r.o_empty, 1);
        chk("rst_aempty", if_r.o_almost_empty, 1);
        chk("rst_full",   if_r.o_full, 0);
        chk("rst_afull",  if_r.o_almost_full, 0);
        chk("rst_rvalid", if_r.o_r_valid, 0);
        chk("rst_rdata",  if_r.o_fifo_r_data, 0);
        chk("rst_ovf",    if_r.o_overflow, 0);
        chk("rst_udf",    if_r.o_underflow, 0);
        chk("rst_f_rvalid", if_f.o_r_valid, 0);

        // Fill A1..A4 with almost-flag tracking (AFULL=3, AEMPTY=1)
        drive_r(1, 0, 'hA1, 0, 0); tick();
        chk("w1_count", if_r.o_count, 1);
        chk("w1_empty", if_r.o_empty, 0);
        chk("w1_aempty", if_r.o_almost_empty, 1);
        drive_r(1, 0, 'hA2, 0, 0); tick();
        chk("w2_aempty", if_r.o_almost_empty, 0);
        chk("w2_afull", if_r.o_almost_full, 0);
        drive_r(1, 0, 'hA3, 0, 0); tick();
        chk("w3_afull", if_r.o_almost_full, 1);
        chk("w3_full", if_r.o_full, 0);
        drive_r(1, 0, 'hA4, 0, 0); tick();
        chk("w4_count", if_r.o_count, 4);
        chk("w4_full", if_r.o_full, 1);
        chk("w4_rvalid", if_r.o_r_valid, 0);

        // Drain with back-to-back reads; data appears one edge after i_r_en
        drive_r(0, 1, '0, 0, 0); tick();
        chk("r1_data", if_r.o_fifo_r_data, 'hA1);
        chk("r1_valid", if_r.o_r_valid, 1);
        chk("r1_count", if_r.o_count, 3);
        tick();
        chk("r2_data", if_r.o_fifo_r_data, 'hA2);
        tick();
        chk("r3_data", if_r.o_fifo_r_data, 'hA3);
        tick();
        chk("r4_data", if_r.o_fifo_r_data, 'hA4);
        chk("r4_empty", if_r.o_empty, 1);
        chk("r4_count", if_r.o_count, 0);
        drive_r(0, 0, '0, 0, 0); tick();
        chk("idle_valid", if_r.o_r_valid, 0);
        chk("idle_hold", if_r.o_fifo_r_data, 'hA4);

        // Second fill after pointer wrap, then simultaneous write+read at full
        for (int i = 1; i <= 4; i++) begin
            drive_r(1, 0, DW'('hE0 + i), 0, 0); tick();
        end
        chk("fill2_full", if_r.o_full, 1);
        drive_r(1, 1, 'hB5, 0, 0); tick();
        chk("wr_rd_full_data", if_r.o_fifo_r_data, 'hE1);
        chk("wr_rd_full_count", if_r.o_count, 4);
        chk("wr_rd_full_ovf", if_r.o_overflow, 0);
        drive_r(1, 0, 'hFF, 0, 0); tick();
        chk("ovf_set", if_r.o_overflow, 1);
        chk("ovf_count", if_r.o_count, 4);
        drive_r(0, 0, '0, 0, 1); tick();
        chk("ovf_clr", if_r.o_overflow, 0);
        drive_r(0, 1, '0, 0, 0); tick();
        chk("d1_data", if_r.o_fifo_r_data, 'hE2);
        tick();
        chk("d2_data", if_r.o_fifo_r_data, 'hE3);
        tick();
        chk("d3_data", if_r.o_fifo_r_data, 'hE4);
        tick();
        chk("d4_data", if_r.o_fifo_r_data, 'hB5);
        chk("d4_empty", if_r.o_empty, 1);

        // Simultaneous write+read at empty: write taken, read rejected
        drive_r(1, 1, 'hC7, 0, 0); tick();
        chk("wr_rd_empty_udf", if_r.o_underflow, 1);
        chk("wr_rd_empty_count", if_r.o_count, 1);
        chk("wr_rd_empty_valid", if_r.o_r_valid, 0);
        drive_r(0, 1, '0, 0, 0); tick();
        chk("c7_data", if_r.o_fifo_r_data, 'hC7);
        chk("c7_valid", if_r.o_r_valid, 1);
        // Clear coinciding with a new rejected read keeps the flag
        drive_r(0, 1, '0, 0, 1); tick();
        chk("udf_clr_collide", if_r.o_underflow, 1);
        drive_r(0, 0, '0, 0, 1); tick();
        chk("udf_clr", if_r.o_underflow, 0);

        // Flush with 3 entries and a same-cycle write
        for (int i = 1; i <= 3; i++) begin
            drive_r(1, 0, DW'('h30 + i), 0, 0); tick();
        end
        chk("pre_flush_count", if_r.o_count, 3);
        drive_r(1, 0, 'h99, 1, 0); tick();
        chk("flush_count", if_r.o_count, 0);
        chk("flush_empty", if_r.o_empty, 1);
        chk("flush_aempty", if_r.o_almost_empty, 1);
        chk("flush_afull", if_r.o_almost_full, 0);
        chk("flush_ovf", if_r.o_overflow, 0);
        drive_r(1, 0, 'h44, 0, 0); tick();
        drive_r(0, 1, '0, 0, 0); tick();
        chk("post_flush_data", if_r.o_fifo_r_data, 'h44);
        drive_r(0, 0, '0, 0, 0);

        // FWFT instance
        drive_f(1, 0, 'hD1); tick();
        chk("fw_first_data", if_f.o_fifo_r_data, 'hD1);
        chk("fw_first_valid", if_f.o_r_valid, 1);
        drive_f(1, 0, 'hD2); tick();
        chk("fw_head_hold", if_f.o_fifo_r_data, 'hD1);
        chk("fw_count2", if_f.o_count, 2);
        drive_f(0, 1, '0); tick();
        chk("fw_pop1_data", if_f.o_fifo_r_data, 'hD2);
        chk("fw_pop1_valid", if_f.o_r_valid, 1);
        tick();
        chk("fw_pop2_valid", if_f.o_r_valid, 0);
        chk("fw_pop2_empty", if_f.o_empty, 1);

        // Reset mid-stream on both instances
        drive_f(1, 0, 'hD3); tick();
        drive_f(1, 0, 'hD4); drive_r(1, 0, 'h55, 0, 0);
        rst = 1'b1; tick();
        rst = 1'b0; drive_f(0, 0, '0); drive_r(0, 0, '0, 0, 0);
        chk("fw_rst_count", if_f.o_count, 0);
        chk("fw_rst_valid", if_f.o_r_valid, 0);
        chk("fw_rst_data", if_f.o_fifo_r_data, 0);
        chk("fw_rst_empty", if_f.o_empty, 1);
        chk("reg_rst_data", if_r.o_fifo_r_data, 0);
        chk("reg_rst_count", if_r.o_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
